// File: rtl/mysystem_fpga_to_hps_0.sv
// Avalon-MM input PIO: synchronizes fabric status bits, captures per-bit edges
// into a write-1-to-clear register and raises a maskable level interrupt.
module mysystem_fpga_to_hps_0 #(
    parameter int WIDTH     = 16,
    parameter int EDGE_TYPE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] clr_vec;
    logic [1:0]       arm_cnt_reg;
    logic             armed;
    logic             mask_wr;
    logic             cap_wr;
    logic [31:0]      readdata_next;
    logic             unused_wdata;

    assign armed   = (arm_cnt_reg == 2'd3);
    assign mask_wr = chipselect & ~write_n & (address == 2'd1);
    assign cap_wr  = chipselect & ~write_n & (address == 2'd3);

    // Bits of writedata above WIDTH-1 are deliberately ignored.
    assign unused_wdata = ^writedata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic raw_edge;
            if (EDGE_TYPE == 0) begin : g_rise
                assign raw_edge = s2_reg[gi] & ~prev_reg[gi];
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign raw_edge = ~s2_reg[gi] & prev_reg[gi];
            end else begin : g_any
                assign raw_edge = s2_reg[gi] ^ prev_reg[gi];
            end
            // A new edge beats a simultaneous clear so no event is lost.
            assign edge_vec[gi] = armed & raw_edge;
            assign clr_vec[gi]  = cap_wr & writedata[gi];
            assign cap_next[gi] = edge_vec[gi] | (cap_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    always_comb begin
        readdata_next = '0;
        case (address)
            2'd0:    readdata_next[WIDTH-1:0] = s2_reg;
            2'd1:    readdata_next[WIDTH-1:0] = mask_reg;
            2'd3:    readdata_next[WIDTH-1:0] = cap_reg;
            default: readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg      <= '0;
            s2_reg      <= '0;
            prev_reg    <= '0;
            arm_cnt_reg <= '0;
            mask_reg    <= '0;
            cap_reg     <= '0;
            readdata    <= '0;
        end else begin
            s1_reg   <= in_port;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
            // Hold off edge detection until the synchronizer holds real samples.
            if (!armed) begin
                arm_cnt_reg <= arm_cnt_reg + 2'd1;
            end
            if (mask_wr) begin
                mask_reg <= writedata[WIDTH-1:0];
            end
            cap_reg  <= cap_next;
            readdata <= readdata_next;
        end
    end

    assign irq = |(cap_reg & mask_reg);

endmodule

// File: doc/mysystem_fpga_to_hps_0.md
# mysystem_fpga_to_hps_0

Avalon-MM slave input port carrying a 16-bit status word from FPGA fabric logic to the HPS over the lightweight HPS-to-FPGA bridge; the return path of the HPS-to-FPGA output PIO. Synchronizes `in_port` into `clk`, captures edges per bit into a sticky register, and raises a maskable level interrupt to the HPS. It sits beside the output PIO on the same bridge, with the same 2-bit word address space.

## Interface
- `WIDTH`, 16: number of input bits; 1..32.
- `EDGE_TYPE`, 0: edge captured; 0 = rising, 1 = falling, 2 = any.
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, asynchronous, active-low; clock `clk`.
- `address`  in  2: word address.
- `chipselect`  in  1: slave select.
- `write_n`  in  1: active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32: write data; bits above `WIDTH-1` ignored.
- `in_port`  in  WIDTH: asynchronous fabric inputs.
- `readdata`  out  32: registered read data, zero-extended above `WIDTH-1`.
- `irq`  out  1: level interrupt to HPS.

## Operation
- Synchronizer: `s1 <= in_port`, `s2 <= s1`, `prev <= s2`, every clock.
- Edge vector, per bit:
  - rising: `s2 & ~prev`
  - falling: `~s2 & prev`
  - any: `s2 ^ prev`
- Arm counter: 2-bit, 0 at reset, increments once per clock up to 3, then holds. The edge vector is forced to 0 while the count is below 3. A bit already high at reset release is therefore never reported as an edge.
- Register map:
  - 0 DATA: read returns `s2`; writes ignored.
  - 1 IRQMASK: read/write, `mask <= writedata[WIDTH-1:0]`.
  - 2: reserved; reads 0, writes ignored.
  - 3 EDGECAP: read returns `cap`. Write-1-to-clear per bit; writing 0 leaves the bit unchanged.
- Capture update, per bit: `cap[i] <= edge[i] | (cap[i] & ~clr[i])`. `clr` is `writedata[i]` when `chipselect & ~write_n & address==3`, else 0. A new edge in the same cycle as a clear wins, and the bit stays 1.
- `irq = |(cap & mask)`, combinational from registers, so it is glitch-free.
- Read path: `readdata <= mux(address)` every clock. No read strobe is used, and reads have no side effects.
- Reset values, all 0: `s1`, `s2`, `prev`, arm count, `mask`, `cap`, `readdata`, `irq`.

## Timing
- Read latency 1: `address` presented at edge N returns data on `readdata` after edge N+1. There is no waitrequest.
- Write takes effect at the clock edge where `chipselect & ~write_n` is sampled. A read of the same register issued on the next cycle returns the new value.
- `in_port` change stable before edge 0:
  - `s2` reflects it after edge 1.
  - `cap` bit set after edge 2 (`s2` vs `prev` compare).
  - `irq` rises after edge 2 if the bit is masked in.
- DATA read: the change is visible on `readdata` after edge 2 when DATA is addressed continuously.
- Clearing `cap` drops `irq` after the same edge, unless another masked bit is set.
- Pulses shorter than one `clk` period may be missed. This is a documented limitation and is not checked.
- Asynchronous reset mid-operation clears all state immediately. The arm window restarts on release, with the first edge detectable after 3 clocks.

## Test plan
- Reset with `in_port=16'hFFFF` held, release, wait 10 clocks -> EDGECAP reads 0, `irq=0`, DATA reads `32'h0000FFFF`.
- `mask=16'h0001`, toggle `in_port[0]` 0->1 -> `irq` high exactly 3 edges after the change; EDGECAP reads `32'h00000001`. Write `32'h1` to addr 3 -> `irq=0` next cycle, EDGECAP reads 0.
- `mask=16'h0000`, rising edge on bit 5 -> EDGECAP reads `32'h20`, `irq` stays 0. Then write `mask=16'h0020` -> `irq` rises after that write edge.
- Rising edge on bit 3 arriving in the same cycle as a write of `32'h8` to addr 3 -> bit 3 of EDGECAP remains 1.
- `EDGE_TYPE=1`, bit 7 goes 0->1 then 1->0 -> only the falling transition sets `cap[7]`. With `EDGE_TYPE=2` both transitions set it, each one after the previous clear.
- Write `32'hDEADBEEF` to addr 0 and addr 2 -> no state change; addr 2 reads 0; DATA still tracks `in_port`.
